// File: rtl/mmcm_drp_reconfig.sv
// DRP initiator: holds the MMCM in reset, read-modify-writes a table of DRP registers, then releases and waits for lock.
// Optional readback verify of every write when DRP_VERIFY_EN is defined; all outputs registered, start ignored while busy.
module mmcm_drp_reconfig #(
  parameter int ENTRY_AW     = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ENTRY_AW:0]   num_entries,
  output logic [ENTRY_AW-1:0] rom_addr,
  input  logic [38:0]         rom_data,
  output logic [6:0]          daddr,
  output logic                den,
  output logic                dwe,
  output logic [15:0]         di,
  input  logic [15:0]         drp_do,
  input  logic                drdy,
  output logic                mmcm_rst,
  input  logic                mmcm_locked,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, FETCH0, FETCH1, RD, RD_WAIT, WR, WR_WAIT,
    VRD, VRD_WAIT, NEXT, RELEASE, WAIT_LOCK
  } state_t;

  state_t            state, state_nx;
  logic [ENTRY_AW:0] idx, count, idx_inc;
  logic [15:0]       keep_mask, wdata;
  logic [CW-1:0]     cnt;
  logic              locked_meta, locked_s;
  logic              fail, finish;
  logic              drdy_to, lock_to;

  assign idx_inc  = idx + (ENTRY_AW+1)'(1);
  assign rom_addr = idx[ENTRY_AW-1:0];
  assign drdy_to  = (cnt == CW'(DRDY_TIMEOUT - 1));
  assign lock_to  = (cnt == CW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fail     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:       if (start) state_nx = ASSERT_RST;
      ASSERT_RST: state_nx = (count == '0) ? RELEASE : FETCH0;
      FETCH0:     state_nx = FETCH1;
      FETCH1:     state_nx = RD;
      RD:         state_nx = RD_WAIT;
      RD_WAIT: begin
        if (drdy)         state_nx = WR;
        else if (drdy_to) begin fail = 1'b1; state_nx = IDLE; end
      end
      WR:         state_nx = WR_WAIT;
      WR_WAIT: begin
`ifdef DRP_VERIFY_EN
        if (drdy)         state_nx = VRD;
`else
        if (drdy)         state_nx = NEXT;
`endif
        else if (drdy_to) begin fail = 1'b1; state_nx = IDLE; end
      end
`ifdef DRP_VERIFY_EN
      VRD:        state_nx = VRD_WAIT;
      VRD_WAIT: begin
        // di still holds the value just written, so it is the reference for the readback
        if (drdy) begin
          if (drp_do != di) begin fail = 1'b1; state_nx = IDLE; end
          else              state_nx = NEXT;
        end else if (drdy_to) begin fail = 1'b1; state_nx = IDLE; end
      end
`endif
      NEXT:       state_nx = (idx_inc == count) ? RELEASE : FETCH0;
      RELEASE:    state_nx = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)     begin finish = 1'b1; state_nx = IDLE; end
        else if (lock_to) begin fail = 1'b1; state_nx = IDLE; end
      end
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      count       <= '0;
      keep_mask   <= '0;
      wdata       <= '0;
      cnt         <= '0;
      daddr       <= '0;
      den         <= 1'b0;
      dwe         <= 1'b0;
      di          <= '0;
      mmcm_rst    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= mmcm_locked;
      locked_s    <= locked_meta;
      done        <= finish;
      // den/dwe look ahead at the next state so the strobe lines up with the RD/WR/VRD cycle itself
      den         <= (state_nx == RD) || (state_nx == WR) || (state_nx == VRD);
      dwe         <= (state_nx == WR);

      if (state == IDLE && start) begin
        count    <= num_entries;
        idx      <= '0;
        error    <= 1'b0;
        busy     <= 1'b1;
        mmcm_rst <= 1'b1;
      end
      if (state == FETCH1) begin
        daddr     <= rom_data[38:32];
        keep_mask <= rom_data[31:16];
        wdata     <= rom_data[15:0];
      end
      if (state == RD_WAIT && drdy)
        di <= (drp_do & keep_mask) | (wdata & ~keep_mask);
      if (state == NEXT)    idx      <= idx_inc;
      if (state == RELEASE) mmcm_rst <= 1'b0;

      if (state == RD || state == WR || state == VRD || state == RELEASE)
        cnt <= '0;
      else if (state == RD_WAIT || state == WR_WAIT || state == VRD_WAIT || state == WAIT_LOCK)
        cnt <= cnt + CW'(1);

      if (finish) busy <= 1'b0;
      if (fail) begin
        error    <= 1'b1;
        mmcm_rst <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule
